// File: rtl/score_digit_sequencer_pkg.sv
// Shared display definitions for the score digit sequencer: nibble width, blank code, FSM states.
// Pure declarations; no timing or flow control of its own.
package score_digit_sequencer_pkg;
  localparam int         NIB_W = 4;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONVERT    = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
endpackage

// File: rtl/score_digit_sequencer_bcd_add3_stage.sv
// Double-dabble correction for one BCD nibble: values 5..9 get +3 before the shift.
// Purely combinational, zero latency, no flow control.
module bcd_add3_stage
  import score_digit_sequencer_pkg::*;
(
  input  logic [NIB_W-1:0] nib_in,
  output logic [NIB_W-1:0] nib_out
);
  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
endmodule

// File: rtl/score_digit_sequencer.sv
// Binary score -> blanked BCD digits via SCORE_W-cycle shift-add-3; commits only on frame_start.
// Latency >= SCORE_W+2 cycles from load; a load while busy is held in one newest-wins pending slot.
module score_digit_sequencer
  import score_digit_sequencer_pkg::*;
#(
  parameter int SCORE_W = 17,
  parameter int NDIGITS = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SCORE_W-1:0]       score,
  input  logic                     load,
  input  logic                     frame_start,
  output logic [NIB_W*NDIGITS-1:0] digits,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);
  localparam int                  BCD_W        = NIB_W * NDIGITS;
  localparam int                  CNT_W        = $clog2(SCORE_W + 1);
  localparam logic [63:0]         MAX_VAL      = pow10(NDIGITS) - 64'd1;
  localparam logic [BCD_W-1:0]    RESET_DIGITS = {{(NDIGITS-1){BLANK}}, 4'd0};

  state_t               state;
  logic [SCORE_W-1:0]   bin;
  logic [BCD_W-1:0]     bcd;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_cap;
  logic                 pend;
  logic [SCORE_W-1:0]   pend_score;

  logic [BCD_W-1:0]         bcd_fix;
  logic [BCD_W+SCORE_W-1:0] shifted;
  logic [SCORE_W-1:0]       idle_src;
  logic                     idle_ovf;
  logic                     pend_ovf;
  logic [BCD_W-1:0]         result;
  logic [BCD_W-1:0]         blanked;
  logic                     lead;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_add3
    bcd_add3_stage u_add3 (
      .nib_in  (bcd[g*NIB_W +: NIB_W]),
      .nib_out (bcd_fix[g*NIB_W +: NIB_W])
    );
  end

  assign shifted  = {bcd_fix, bin} << 1;
  assign idle_src = load ? score : pend_score;
  assign idle_ovf = 64'(idle_src) > MAX_VAL;
  assign pend_ovf = 64'(pend_score) > MAX_VAL;
  assign result   = ovf_cap ? {NDIGITS{4'd9}} : bcd;

  // Leading-zero scan from the top digit down; digit 0 always shows.
  always_comb begin
    blanked = result;
    lead    = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      if (lead && result[i*NIB_W +: NIB_W] == 4'd0) blanked[i*NIB_W +: NIB_W] = BLANK;
      else                                          lead = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf_cap    <= 1'b0;
      pend       <= 1'b0;
      pend_score <= '0;
      digits     <= RESET_DIGITS;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && state != IDLE) begin
        pend       <= 1'b1;
        pend_score <= score;
      end
      case (state)
        IDLE: begin
          busy <= load || pend;
          if (load || pend) begin
            bin     <= idle_src;
            bcd     <= '0;
            cnt     <= CNT_W'(SCORE_W);
            ovf_cap <= idle_ovf;
            pend    <= 1'b0;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= shifted;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            digits   <= blanked;
            overflow <= ovf_cap;
            done     <= 1'b1;
            if (pend) begin
              // Chain straight into the pending value; a load this cycle re-arms pending.
              bin     <= pend_score;
              bcd     <= '0;
              cnt     <= CNT_W'(SCORE_W);
              ovf_cap <= pend_ovf;
              pend    <= load;
              state   <= CONVERT;
            end else begin
              busy  <= load;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed bench for score_digit_sequencer: 6-digit default instance plus a 4-digit instance for overflow.
module tb_score_digit_sequencer;
  localparam int SW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic          load4 = 1'b0;
  logic          frame_start = 1'b0;
  logic [SW-1:0] score = '0;
  logic [23:0]   digits;
  logic [15:0]   digits4;
  logic          busy, done, overflow;
  logic          busy4, done4, overflow4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_mode = 0;
  int done_cnt = 0;
  int done4_cnt = 0;

  typedef struct {
    logic [SW-1:0] s;
    logic [23:0]   d;
    logic          o;
  } vec_t;

  vec_t tv6[9];
  vec_t tv4[8];

  score_digit_sequencer #(.SCORE_W(SW), .NDIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .load(load), .frame_start(frame_start),
    .digits(digits), .busy(busy), .done(done), .overflow(overflow)
  );

  score_digit_sequencer #(.SCORE_W(SW), .NDIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .score(score), .load(load4), .frame_start(frame_start),
    .digits(digits4), .busy(busy4), .done(done4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done4) done4_cnt <= done4_cnt + 1;
  end

  // fs_mode: 0 = frame_start low, 1 = held high, 2 = one pulse every 100 cycles
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    frame_start = (fs_mode == 1) || (fs_mode == 2 && (cyc % 100) == 0);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input bit use4, output int lat, output bit early);
    logic [23:0] snap;
    snap  = use4 ? {8'h0, digits4} : digits;
    lat   = 0;
    early = 1'b0;
    while (!(use4 ? done4 : done) && lat < 300) begin
      tick();
      lat++;
      if (!(use4 ? done4 : done) && (use4 ? {8'h0, digits4} : digits) !== snap) early = 1'b1;
    end
    if (lat >= 300) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 300 cycles, expected a done pulse");
    end
  endtask

  task automatic run_conv(input logic [SW-1:0] s, input bit use4, output int lat, output bit early);
    int l;
    score = s;
    if (use4) load4 = 1'b1;
    else      load  = 1'b1;
    tick();
    load  = 1'b0;
    load4 = 1'b0;
    wait_done(use4, l, early);
    lat = l + 1;
  endtask

  initial begin
    int  lat;
    bit  early;
    int  d0;

    tv6[0] = '{17'd2048,   24'hFF2048, 1'b0};
    tv6[1] = '{17'd0,      24'hFFFFF0, 1'b0};
    tv6[2] = '{17'd131071, 24'h131071, 1'b0};
    tv6[3] = '{17'd99999,  24'hF99999, 1'b0};
    tv6[4] = '{17'd100000, 24'h100000, 1'b0};
    tv6[5] = '{17'd10,     24'hFFFF10, 1'b0};
    tv6[6] = '{17'd9,      24'hFFFFF9, 1'b0};
    tv6[7] = '{17'd1000,   24'hFF1000, 1'b0};
    tv6[8] = '{17'd70005,  24'hF70005, 1'b0};

    tv4[0] = '{17'd12345,  24'h009999, 1'b1};
    tv4[1] = '{17'd7,      24'h00FFF7, 1'b0};
    tv4[2] = '{17'd9999,   24'h009999, 1'b0};
    tv4[3] = '{17'd10000,  24'h009999, 1'b1};
    tv4[4] = '{17'd0,      24'h00FFF0, 1'b0};
    tv4[5] = '{17'd100,    24'h00F100, 1'b0};
    tv4[6] = '{17'd105,    24'h00F105, 1'b0};
    tv4[7] = '{17'd54321,  24'h009999, 1'b1};

    // Reset state
    repeat (3) tick();
    check("rst_digits",   digits,   24'hFFFFF0);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_digits4",  digits4,  16'hFFF0);
    rst_n = 1'b1;

    // Long idle with frame pulses
    fs_mode = 2;
    d0 = done_cnt;
    repeat (1000) tick();
    check("idle_digits", digits, 24'hFFFFF0);
    check("idle_busy",   busy,   1'b0);
    check("idle_done_count", done_cnt - d0, 0);

    // 2048 with frame_start every 100 cycles
    d0 = done_cnt;
    score = 17'd2048;
    load  = 1'b1;
    tick();
    load = 1'b0;
    check("busy_after_load", busy, 1'b1);
    wait_done(1'b0, lat, early);
    check("f2048_digits", digits, 24'hFF2048);
    check("f2048_no_early_change", early, 1'b0);
    check("f2048_on_frame", ((cyc - 1) % 100) == 0, 1'b1);
    check("f2048_min_latency", (lat + 1) >= SW + 1, 1'b1);
    repeat (20) tick();
    check("f2048_done_count", done_cnt - d0, 1);
    check("f2048_busy_after", busy, 1'b0);

    // Pending load three cycles after the first
    d0 = done_cnt;
    score = 17'd1000;
    load  = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    score = 17'd131071;
    load  = 1'b1;
    tick();
    load = 1'b0;
    wait_done(1'b0, lat, early);
    check("pend_first_digits", digits, 24'hFF1000);
    tick();
    check("pend_busy_held", busy, 1'b1);
    check("pend_done_one_cycle", done, 1'b0);
    wait_done(1'b0, lat, early);
    check("pend_second_digits", digits, 24'h131071);
    check("pend_second_waited_frame", lat >= 90, 1'b1);
    tick();
    check("pend_busy_low", busy, 1'b0);
    check("pend_done_count", done_cnt - d0, 2);

    // Table: frame_start held high, minimum latency path
    fs_mode = 1;
    for (int i = 0; i < 9; i++) begin
      run_conv(tv6[i].s, 1'b0, lat, early);
      check($sformatf("tv6_%0d_digits", i), digits, tv6[i].d);
      check($sformatf("tv6_%0d_ovf", i), overflow, tv6[i].o);
      check($sformatf("tv6_%0d_latency", i), (lat >= SW + 1) && (lat <= SW + 2), 1'b1);
      tick();
      check($sformatf("tv6_%0d_done_pulse", i), done, 1'b0);
    end

    // Table: 4-digit instance, overflow saturation
    for (int i = 0; i < 8; i++) begin
      run_conv(tv4[i].s, 1'b1, lat, early);
      check($sformatf("tv4_%0d_digits", i), {8'h0, digits4}, tv4[i].d);
      check($sformatf("tv4_%0d_ovf", i), overflow4, tv4[i].o);
      tick();
    end

    // Reset mid-conversion
    fs_mode = 0;
    score = 17'd2048;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("arst_digits",    digits,    24'hFFFFF0);
    check("arst_busy",      busy,      1'b0);
    check("arst_overflow4", overflow4, 1'b0);
    check("arst_digits4",   digits4,   16'hFFF0);
    tick();
    rst_n   = 1'b1;
    fs_mode = 1;
    d0 = done_cnt;
    repeat (60) tick();
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_digits_hold", digits, 24'hFFFFF0);
    check("arst_busy_hold", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_digit_sequencer.md
# score_digit_sequencer

Converts the binary game score into per-digit BCD values for a row of seven-segment digit renderers, with leading-zero blanking. Conversion runs sequentially over multiple cycles (shift-add-3). Committed digits change only on a frame boundary, so a score never tears mid-frame. Sits between the game-logic score register and the digit renderer instances; each renderer's 4-bit value input is driven from one nibble of `digits`.

## Interface
Parameters:
- `SCORE_W`, 17: width of the binary score input.
- `NDIGITS`, 6: number of displayed decimal digits; digit 0 is least significant.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `score`  in  SCORE_W  binary score; sampled only when `load` is 1.
- `load`  in  1  single-cycle strobe requesting display of `score`.
- `frame_start`  in  1  one-cycle pulse at the start of each video frame (vertical blank entry).
- `digits`  out  4*NDIGITS  committed digit values; nibble i is `digits[4i+3:4i]`; values 0–9 or 4'hF (blank).
- `busy`  out  1  high whenever state is not IDLE or a load is pending.
- `done`  out  1  one-cycle pulse on the cycle `digits` takes a new value.
- `overflow`  out  1  sticky per commit: 1 if the last committed score exceeded 10^NDIGITS − 1.

## Operation
- States: IDLE, CONVERT, WAIT_FRAME.
- IDLE + `load`: capture `score` into the shift register, clear the BCD accumulator (4*NDIGITS bits), bit counter = SCORE_W, go to CONVERT.
- CONVERT, each cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - Then shift {BCD, bin} left by 1.
  - Decrement the counter; after SCORE_W shifts, go to WAIT_FRAME.
- Overflow: compare the captured score against 10^NDIGITS − 1 at capture, using a constant computed at elaboration. If larger, the conversion result is replaced by all nibbles = 9 and the overflow flag is set for this result.
- Blanking: at commit, every nibble above digit 0 that is 0 and has only zeros above it becomes 4'hF. Digit 0 is never blanked, so a score of 0 shows "0".
- WAIT_FRAME + `frame_start`: write the blanked result to `digits`, update `overflow`, pulse `done`, go to IDLE.
- `load` while not IDLE: latch `score` into a single pending register (newest wins) and set pending.
  - On the commit cycle with pending set: clear pending and go directly to CONVERT with the pending value, not IDLE.
  - `load` on the commit cycle itself updates pending and is not lost.
- `frame_start` outside WAIT_FRAME is ignored.

## Timing
- Reset values:
  - `digits` = digit 0 = 0, all other nibbles = 4'hF.
  - `busy` = 0, `done` = 0, `overflow` = 0.
  - State = IDLE, pending cleared.
- `load` at edge N: CONVERT occupies cycles N+1 … N+SCORE_W; state is WAIT_FRAME from N+SCORE_W+1.
- Minimum load-to-`digits` latency is SCORE_W+2 cycles, when `frame_start` is already high on the first WAIT_FRAME cycle.
- `digits`, `overflow` and `done` change on the same edge as the commit. `done` is high for exactly that one cycle.
- `busy` is registered. It rises the cycle after `load` and falls the cycle after commit unless pending was set.
- Reset asserted mid-CONVERT or mid-WAIT_FRAME: the conversion is abandoned, pending is cleared, and outputs return to reset values immediately (asynchronous).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared display package holds:
  - the blank code (4'hF);
  - the digit nibble width (4);
  - the state encoding (IDLE, CONVERT, WAIT_FRAME).
- One natural sub-module, `bcd_add3_stage`: the combinational per-nibble ≥5 → +3 correction, instantiated NDIGITS times in a generate loop.
- The blanking logic stays in the top-level block: a priority scan from the MSB nibble downward.

## Test plan
- Reset, then idle for 1000 cycles → `digits` = 0xFFFFF0, `busy` = 0, `done` never pulses.
- `load` with `score` = 2048, `frame_start` every 100 cycles → `digits` = 0xFF2048 on the first `frame_start` at or after cycle SCORE_W+1 after `load`; `done` pulses once; no change before that frame.
- `load` with 1000, then `load` with 131071 three cycles later → commit of 0xFF1000, then immediate reconversion, then commit of 0x131071 on the following frame; two `done` pulses.
- With NDIGITS = 4: `load` with 12345 → `digits` = 0x9999, `overflow` = 1; next `load` with 7 → 0xFFF7, `overflow` = 0.
- `load` with 0 after a nonzero commit → `digits` = 0xFFFFF0.
- Assert `rst_n` low during CONVERT, then release and hold `frame_start` high → reset values are restored, no `done` pulse, `digits` stays 0xFFFFF0.
